// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg: shared state encodings and default sizing for the run controller
package proc_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_COMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;
  localparam int NUM_CORES_DEF = 3;
  localparam int CNT_W_DEF     = 16;
  localparam int TIMEOUT_DEF   = 1024;
endpackage

// File: rtl/process_run_controller_if.sv
// process_run_controller_if: host/loader/core handshake bundle for the run controller
interface process_run_controller_if #(
  parameter int NUM_CORES = 3,
  parameter int CNT_W     = 16
);
  logic                 start_process;
  logic                 load_done;
  logic [NUM_CORES-1:0] core_done;
  logic                 load_start;
  logic                 core_start;
  logic [1:0]           status;
  logic [CNT_W-1:0]     cycle_count;
  logic                 error;
  modport master (
    output start_process, load_done, core_done,
    input  load_start, core_start, status, cycle_count, error
  );
  modport slave (
    input  start_process, load_done, core_done,
    output load_start, core_start, status, cycle_count, error
  );
endinterface

// File: rtl/process_run_controller_phase_watchdog.sv
// phase_watchdog: clearable per-phase cycle counter flagging TIMEOUT-1 while enabled
module phase_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic fast_clock,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = $clog2(TIMEOUT);
  logic [W-1:0] r_cnt;
  always_ff @(posedge fast_clock or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= i_clear ? '0 : i_en ? r_cnt + W'(1) : r_cnt;
  end
  assign o_expired = i_en && (r_cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/process_run_controller.sv
// process_run_controller: start-edge triggered load/compute sequencer with cycle count and watchdog
module process_run_controller
  import proc_ctrl_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input logic fast_clock,
  input logic rst_n,
  process_run_controller_if.slave bus
);
  state_t               r_state, w_next;
  logic                 r_start_q, r_load_start, r_core_start, r_error;
  logic [NUM_CORES-1:0] r_mask;
  logic [CNT_W-1:0]     r_cycle_count;
  logic                 w_go, w_all, w_run, w_clear, w_expired, w_to_err, w_launch;
  assign w_go     = bus.start_process && !r_start_q;
  assign w_all    = &(r_mask | bus.core_done);
  assign w_run    = (r_state == ST_LOAD) || (r_state == ST_COMP);
  assign w_clear  = (w_next != r_state);
  assign w_launch = (r_state == ST_IDLE) && w_go;
  phase_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .fast_clock (fast_clock),
    .rst_n      (rst_n),
    .i_clear    (w_clear),
    .i_en       (w_run),
    .o_expired  (w_expired)
  );
  // the exit condition outranks a simultaneous timeout
  always_comb begin
    w_next   = r_state;
    w_to_err = 1'b0;
    case (r_state)
      ST_IDLE: w_next = w_go ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        w_next   = bus.load_done ? ST_COMP : w_expired ? ST_DONE : ST_LOAD;
        w_to_err = w_expired && !bus.load_done;
      end
      ST_COMP: begin
        w_next   = (w_all || w_expired) ? ST_DONE : ST_COMP;
        w_to_err = w_expired && !w_all;
      end
      default: w_next = bus.start_process ? ST_DONE : ST_IDLE;
    endcase
  end
  always_ff @(posedge fast_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_start_q     <= 1'b0;
      r_load_start  <= 1'b0;
      r_core_start  <= 1'b0;
      r_mask        <= '0;
      r_cycle_count <= '0;
      r_error       <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_start_q     <= bus.start_process;
      r_load_start  <= w_launch;
      r_core_start  <= (r_state == ST_LOAD) && bus.load_done;
      r_mask        <= (r_state == ST_COMP) ? (r_mask | bus.core_done) : '0;
      r_cycle_count <= w_launch ? '0 : (w_run && !(&r_cycle_count)) ? r_cycle_count + CNT_W'(1) : r_cycle_count;
      r_error       <= w_launch ? 1'b0 : (r_error || w_to_err);
    end
  end
  assign bus.status      = r_state;
  assign bus.load_start  = r_load_start;
  assign bus.core_start  = r_core_start;
  assign bus.cycle_count = r_cycle_count;
  assign bus.error       = r_error;
endmodule

// File: tb/tb_process_run_controller.sv
// tb_process_run_controller: directed table and sequence checks for the run controller
module tb_process_run_controller;
  import proc_ctrl_pkg::*;
  logic fast_clock = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  always #5 fast_clock = ~fast_clock;
  process_run_controller_if #(.NUM_CORES(3), .CNT_W(16)) bus ();
  process_run_controller_if #(.NUM_CORES(3), .CNT_W(16)) bus2 ();
  process_run_controller #(.NUM_CORES(3), .CNT_W(16), .TIMEOUT(1024)) dut (
    .fast_clock (fast_clock),
    .rst_n      (rst_n),
    .bus        (bus.slave)
  );
  process_run_controller #(.NUM_CORES(3), .CNT_W(16), .TIMEOUT(8)) dut_wd (
    .fast_clock (fast_clock),
    .rst_n      (rst_n),
    .bus        (bus2.slave)
  );
  typedef struct {
    logic        st;
    logic        ld;
    logic [2:0]  cd;
    logic [1:0]  est;
    logic        els;
    logic        ecs;
    logic [15:0] ecnt;
    logic        eerr;
  } vec_t;
  vec_t tbl [11];
  task automatic tick();
    @(posedge fast_clock);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_all(input string name, input logic [1:0] est, input logic els, input logic ecs,
                         input logic [15:0] ecnt, input logic eerr);
    chk({name, ".status"}, 32'(bus.status), 32'(est));
    chk({name, ".load_start"}, 32'(bus.load_start), 32'(els));
    chk({name, ".core_start"}, 32'(bus.core_start), 32'(ecs));
    chk({name, ".cycle_count"}, 32'(bus.cycle_count), 32'(ecnt));
    chk({name, ".error"}, 32'(bus.error), 32'(eerr));
  endtask
  task automatic run_table(input string name);
    for (int i = 0; i < 11; i++) begin
      bus.start_process = tbl[i].st;
      bus.load_done     = tbl[i].ld;
      bus.core_done     = tbl[i].cd;
      tick();
      chk_all($sformatf("%s[%0d]", name, i), tbl[i].est, tbl[i].els, tbl[i].ecs, tbl[i].ecnt, tbl[i].eerr);
    end
  endtask
  initial begin
    tbl[0]  = '{1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 3'd0, 2'd1, 1'b1, 1'b0, 16'd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 3'd0, 2'd1, 1'b0, 1'b0, 16'd1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 3'd0, 2'd1, 1'b0, 1'b0, 16'd2, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 3'd0, 2'd2, 1'b0, 1'b1, 16'd3, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0, 16'd4, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 3'd7, 2'd3, 1'b0, 1'b0, 16'd5, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 3'd0, 2'd3, 1'b0, 1'b0, 16'd5, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 16'd5, 1'b0};
    bus.start_process  = 1'b0; bus.load_done  = 1'b0; bus.core_done  = 3'd0;
    bus2.start_process = 1'b0; bus2.load_done = 1'b0; bus2.core_done = 3'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk_all("reset", 2'd0, 1'b0, 1'b0, 16'd0, 1'b0);
    repeat (7) tick();
    run_table("basic");
    // staggered single-core completions at +1, +4, +9 after core_start
    bus.start_process = 1'b1; tick();
    chk_all("stag.e", 2'd1, 1'b1, 1'b0, 16'd0, 1'b0);
    bus.load_done = 1'b1; tick();
    chk_all("stag.l", 2'd2, 1'b0, 1'b1, 16'd1, 1'b0);
    bus.load_done = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      bus.core_done = (k == 1) ? 3'b001 : (k == 4) ? 3'b010 : (k == 9) ? 3'b100 : 3'b000;
      tick();
      chk_all($sformatf("stag.c%0d", k), (k == 9) ? 2'd3 : 2'd2, 1'b0, 1'b0, 16'(1 + k), 1'b0);
    end
    bus.core_done = 3'd0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("hold%0d.status", k), 32'(bus.status), 32'd3);
      chk($sformatf("hold%0d.cnt", k), 32'(bus.cycle_count), 32'd10);
    end
    bus.start_process = 1'b0; tick();
    chk_all("restart.idle", 2'd0, 1'b0, 1'b0, 16'd10, 1'b0);
    bus.start_process = 1'b1; tick();
    chk_all("restart.e", 2'd1, 1'b1, 1'b0, 16'd0, 1'b0);
    bus.load_done = 1'b1; tick();
    chk_all("glitch.l", 2'd2, 1'b0, 1'b1, 16'd1, 1'b0);
    bus.load_done = 1'b0;
    bus.start_process = 1'b0; tick();
    chk_all("glitch.fall", 2'd2, 1'b0, 1'b0, 16'd2, 1'b0);
    bus.start_process = 1'b1; tick();
    chk_all("glitch.rise", 2'd2, 1'b0, 1'b0, 16'd3, 1'b0);
    bus.start_process = 1'b0; tick();
    chk_all("glitch.fall2", 2'd2, 1'b0, 1'b0, 16'd4, 1'b0);
    bus.start_process = 1'b1; bus.core_done = 3'b111; tick();
    chk_all("glitch.done", 2'd3, 1'b0, 1'b0, 16'd5, 1'b0);
    bus.core_done = 3'd0; tick();
    chk_all("glitch.hold", 2'd3, 1'b0, 1'b0, 16'd5, 1'b0);
    bus.start_process = 1'b0; tick();
    chk_all("glitch.idle", 2'd0, 1'b0, 1'b0, 16'd5, 1'b0);
    // asynchronous reset asserted mid-COMPUTE, between clock edges
    bus.start_process = 1'b1; tick();
    chk_all("ares.e", 2'd1, 1'b1, 1'b0, 16'd0, 1'b0);
    bus.load_done = 1'b1; tick();
    chk_all("ares.l", 2'd2, 1'b0, 1'b1, 16'd1, 1'b0);
    bus.load_done = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all("ares.now", 2'd0, 1'b0, 1'b0, 16'd0, 1'b0);
    bus.start_process = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (7) tick();
    run_table("rerun");
    // watchdog instance with TIMEOUT 8
    bus2.start_process = 1'b1; tick();
    chk("wd.e.status", 32'(bus2.status), 32'd1);
    chk("wd.e.load_start", 32'(bus2.load_start), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("wd.t%0d.status", k), 32'(bus2.status), (k == 8) ? 32'd3 : 32'd1);
      chk($sformatf("wd.t%0d.cnt", k), 32'(bus2.cycle_count), 32'(k));
      chk($sformatf("wd.t%0d.error", k), 32'(bus2.error), (k == 8) ? 32'd1 : 32'd0);
      chk($sformatf("wd.t%0d.core_start", k), 32'(bus2.core_start), 32'd0);
    end
    bus2.start_process = 1'b0; tick();
    chk("wd.idle.status", 32'(bus2.status), 32'd0);
    chk("wd.idle.error", 32'(bus2.error), 32'd1);
    bus2.start_process = 1'b1; tick();
    chk("wd.e2.status", 32'(bus2.status), 32'd1);
    chk("wd.e2.error", 32'(bus2.error), 32'd0);
    chk("wd.e2.cnt", 32'(bus2.cycle_count), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      bus2.load_done = (k == 8);
      tick();
      chk($sformatf("wd.x%0d.status", k), 32'(bus2.status), (k == 8) ? 32'd2 : 32'd1);
      chk($sformatf("wd.x%0d.core_start", k), 32'(bus2.core_start), (k == 8) ? 32'd1 : 32'd0);
      chk($sformatf("wd.x%0d.error", k), 32'(bus2.error), 32'd0);
    end
    chk("wd.x.cnt", 32'(bus2.cycle_count), 32'd8);
    bus2.load_done = 1'b0; bus2.core_done = 3'b111; tick();
    chk("wd.fin.status", 32'(bus2.status), 32'd3);
    chk("wd.fin.cnt", 32'(bus2.cycle_count), 32'd9);
    chk("wd.fin.error", 32'(bus2.error), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
